// File: rtl/qrisc32_if_prefetch.sv
// Instruction-fetch stage with a prefetch FIFO: pipelines up to DEPTH reads on the
// instruction bus, buffers {pc,instr} pairs and drops stale responses after a redirect.
module qrisc32_if_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        areset,
  output logic [ADDR_W-1:0]           imem_address,
  output logic                        imem_rd,
  input  logic                        imem_wait_req,
  input  logic [DATA_W-1:0]           imem_data_r,
  input  logic                        imem_data_valid,
  input  logic                        pipe_stall,
  input  logic                        new_address_valid,
  input  logic [ADDR_W-1:0]           new_address,
  output logic [DATA_W-1:0]           instruction,
  output logic [ADDR_W-1:0]           pc,
  output logic                        instr_valid,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0] respPc_q, respPc_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  outst_q, outst_d;
  logic [LVL_W-1:0]  drop_q, drop_d;

  logic [ADDR_W-1:0] pcMem [DEPTH];
  logic [DATA_W-1:0] instrMem [DEPTH];

  logic [LVL_W-1:0]  live;
  logic [LVL_W:0]    credit;
  logic              reqEn;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifoValid;
  logic [ADDR_W-1:0] target;

  // Credit counts buffered words plus non-stale reads, so a push never meets a full FIFO.
  always_comb begin
    live      = outst_q - drop_q;
    credit    = {1'b0, level_q} + {1'b0, live};
    fifoValid = (level_q != '0);
    reqEn     = ~areset & ~new_address_valid
                & (credit < (LVL_W+1)'(DEPTH))
                & (outst_q < LVL_W'(DEPTH));
    accept    = reqEn & ~imem_wait_req;
    push      = imem_data_valid & (drop_q == '0) & ~new_address_valid;
    pop       = fifoValid & ~pipe_stall & ~new_address_valid;
    target    = {new_address[ADDR_W-1:2], 2'b00};
  end

  always_comb begin
    fetchPc_d = fetchPc_q;
    respPc_d  = respPc_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    level_d   = level_q;
    outst_d   = outst_q + LVL_W'(accept) - LVL_W'(imem_data_valid);
    drop_d    = drop_q;
    if (new_address_valid) begin
      fetchPc_d = target;
      respPc_d  = target;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      level_d   = '0;
      drop_d    = outst_q - LVL_W'(imem_data_valid);
    end else begin
      if (accept) fetchPc_d = fetchPc_q + ADDR_W'(4);
      if (push) begin
        respPc_d = respPc_q + ADDR_W'(4);
        wrPtr_d  = wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_d = rdPtr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      if (imem_data_valid && drop_q != '0) drop_d = drop_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fetchPc_q <= RESET_PC;
      respPc_q  <= RESET_PC;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      level_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      respPc_q  <= respPc_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      level_q   <= level_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr_q]    <= respPc_q;
      instrMem[wrPtr_q] <= imem_data_r;
    end
  end

  assign imem_rd      = reqEn;
  assign imem_address = fetchPc_q;
  assign instr_valid  = fifoValid;
  assign instruction  = fifoValid ? instrMem[rdPtr_q] : '0;
  assign pc           = fifoValid ? pcMem[rdPtr_q] : respPc_q;
  assign fifo_level   = level_q;

  // A response that would land in a full FIFO means the memory broke the request protocol.
  assert property (@(posedge clk) disable iff (areset)
    !(push && !pop && level_q == LVL_W'(DEPTH)));

endmodule
